status_wr_arb: RTL

Arbiter and sequencer for status-register writes in the Jac1-8 core. Both the ALU and the instruction decoder produce status bits. This block buffers each source's request in a one-entry slot and serialises the writes, at most one per cycle. It drives the Status_reg write port (`wr_en`, `sel_stat_in_alu_decoder`, `alu_status`, `dec_status`), so neither source touches the register directly.

---
 rtl/status_arb_pkg.sv | 13 +
 rtl/status_slot.sv | 50 +++++
 rtl/status_wr_arb.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/status_arb_pkg.sv
// status_arb_pkg: shared types and constants for the status-register write arbiter.
//   NUM_STATUS_BITS_DEFAULT : default width of every status vector
//   stat_src_t              : write source, encoded exactly as the Status_reg select line
package status_arb_pkg;

    localparam int unsigned NUM_STATUS_BITS_DEFAULT = 4;

    typedef enum logic {
        SRC_DEC = 1'b0,
        SRC_ALU = 1'b1
    } stat_src_t;

endpackage

// File: rtl/status_slot.sv
// status_slot: one-entry valid/data buffer for a single status-write source.
// Ports:
//   clk_i   : clock
//   rst_i   : asynchronous active-high reset, empties the slot
//   load_i  : capture data_i and mark valid (wins over clear_i)
//   clear_i : drop the held entry
//   data_i  : value to capture
//   valid_o : slot holds an entry
//   data_o  : held entry
module status_slot #(
    parameter int unsigned Width = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic             clear_i,
    input  logic [Width-1:0] data_i,
    output logic             valid_o,
    output logic [Width-1:0] data_o
);

    logic             valid_q, valid_d;
    logic [Width-1:0] data_q, data_d;

    // A load in the same edge as a clear is a refill: the slot stays valid.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end else if (clear_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/status_wr_arb.sv
// status_wr_arb: buffers ALU and decoder status writes in one-entry slots and issues them to
// the Status_reg write port, at most one per cycle, round-robin on conflict.
// Optional feature macro: STATUS_ARB_SHADOW_EN (shadow save/restore of the status value).
// Ports:
//   clk_i, res_i                : clock, asynchronous active-high reset
//   status_cur_i                : (shadow build) current Status_reg output
//   shadow_save_i               : (shadow build) capture status_cur_i into the shadow
//   shadow_restore_i            : (shadow build) write the shadow back via the decoder path
//   alu_req_i, alu_stat_in_i    : ALU write offer and value
//   alu_rdy_o                   : ALU slot accepts this cycle
//   dec_req_i, dec_stat_in_i    : decoder write offer and value
//   dec_rdy_o                   : decoder slot accepts this cycle
//   wr_en_o                     : Status_reg write enable (registered)
//   sel_stat_in_alu_decoder_o   : 1 = ALU, 0 = decoder (registered)
//   alu_status_o, dec_status_o  : values presented to Status_reg (registered)
//   busy_o                      : either slot holds a pending write
module status_wr_arb
    import status_arb_pkg::*;
#(
    parameter int unsigned NumStatusBits = NUM_STATUS_BITS_DEFAULT
) (
    input  logic                     clk_i,
    input  logic                     res_i,
`ifdef STATUS_ARB_SHADOW_EN
    input  logic [NumStatusBits-1:0] status_cur_i,
    input  logic                     shadow_save_i,
    input  logic                     shadow_restore_i,
`endif
    input  logic                     alu_req_i,
    input  logic [NumStatusBits-1:0] alu_stat_in_i,
    output logic                     alu_rdy_o,
    input  logic                     dec_req_i,
    input  logic [NumStatusBits-1:0] dec_stat_in_i,
    output logic                     dec_rdy_o,
    output logic                     wr_en_o,
    output logic                     sel_stat_in_alu_decoder_o,
    output logic [NumStatusBits-1:0] alu_status_o,
    output logic [NumStatusBits-1:0] dec_status_o,
    output logic                     busy_o
);

    logic                     alu_valid, dec_valid;
    logic [NumStatusBits-1:0] alu_data, dec_data;
    logic                     alu_load, dec_load;
    logic                     grant_alu, grant_dec;
    logic                     restore_issue;
    logic [NumStatusBits-1:0] restore_data;

    stat_src_t                last_grant_q, last_grant_d;
    logic                     wr_en_q, wr_en_d;
    stat_src_t                sel_q, sel_d;
    logic [NumStatusBits-1:0] alu_status_q, alu_status_d;
    logic [NumStatusBits-1:0] dec_status_q, dec_status_d;

`ifdef STATUS_ARB_SHADOW_EN
    logic [NumStatusBits-1:0] shadow_q;
    logic                     restore_pend_q;
    logic [NumStatusBits-1:0] restore_data_q;

    // The restore value is taken from the shadow at request time, so a save in the same
    // edge only affects later restores.
    always_ff @(posedge clk_i or posedge res_i) begin
        if (res_i) begin
            shadow_q       <= '0;
            restore_pend_q <= 1'b0;
            restore_data_q <= '0;
        end else begin
            if (shadow_save_i) begin
                shadow_q <= status_cur_i;
            end
            // A pending restore always issues in the following cycle.
            restore_pend_q <= shadow_restore_i;
            if (shadow_restore_i) begin
                restore_data_q <= shadow_q;
            end
        end
    end

    assign restore_issue = restore_pend_q;
    assign restore_data  = restore_data_q;
`else
    assign restore_issue = 1'b0;
    assign restore_data  = '0;
`endif

    // Grant depends only on registered state, keeping req -> rdy free of combinational paths.
    always_comb begin
        grant_alu = 1'b0;
        grant_dec = 1'b0;
        if (!restore_issue) begin
            if (alu_valid && dec_valid) begin
                if (last_grant_q == SRC_DEC) begin
                    grant_alu = 1'b1;
                end else begin
                    grant_dec = 1'b1;
                end
            end else begin
                grant_alu = alu_valid;
                grant_dec = dec_valid;
            end
        end
    end

    assign alu_rdy_o = !res_i && (!alu_valid || grant_alu);
    assign dec_rdy_o = !res_i && (!dec_valid || grant_dec);
    assign alu_load  = alu_req_i && alu_rdy_o;
    assign dec_load  = dec_req_i && dec_rdy_o;

    status_slot #(
        .Width(NumStatusBits)
    ) u_alu_slot (
        .clk_i  (clk_i),
        .rst_i  (res_i),
        .load_i (alu_load),
        .clear_i(grant_alu),
        .data_i (alu_stat_in_i),
        .valid_o(alu_valid),
        .data_o (alu_data)
    );

    status_slot #(
        .Width(NumStatusBits)
    ) u_dec_slot (
        .clk_i  (clk_i),
        .rst_i  (res_i),
        .load_i (dec_load),
        .clear_i(grant_dec),
        .data_i (dec_stat_in_i),
        .valid_o(dec_valid),
        .data_o (dec_data)
    );

    // Issue stage: the data output of the non-selected source keeps its value.
    always_comb begin
        wr_en_d      = 1'b0;
        sel_d        = sel_q;
        alu_status_d = alu_status_q;
        dec_status_d = dec_status_q;
        last_grant_d = last_grant_q;
        if (restore_issue) begin
            wr_en_d      = 1'b1;
            sel_d        = SRC_DEC;
            dec_status_d = restore_data;
        end else if (grant_alu) begin
            wr_en_d      = 1'b1;
            sel_d        = SRC_ALU;
            alu_status_d = alu_data;
            last_grant_d = SRC_ALU;
        end else if (grant_dec) begin
            wr_en_d      = 1'b1;
            sel_d        = SRC_DEC;
            dec_status_d = dec_data;
            last_grant_d = SRC_DEC;
        end
    end

    always_ff @(posedge clk_i or posedge res_i) begin
        if (res_i) begin
            wr_en_q      <= 1'b0;
            sel_q        <= SRC_DEC;
            alu_status_q <= '0;
            dec_status_q <= '0;
            last_grant_q <= SRC_DEC;
        end else begin
            wr_en_q      <= wr_en_d;
            sel_q        <= sel_d;
            alu_status_q <= alu_status_d;
            dec_status_q <= dec_status_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign wr_en_o                   = wr_en_q;
    assign sel_stat_in_alu_decoder_o = sel_q;
    assign alu_status_o              = alu_status_q;
    assign dec_status_o              = dec_status_q;
    assign busy_o                    = alu_valid || dec_valid;

endmodule
